// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote, one-entry valid/ready output register.
// Optional break detection is compiled in when UART_RX_BREAK_EN is defined.
module uart_rx_os #(
  parameter int CLK_FREQ   = 30_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV) + 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_RX_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_exp(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
  logic [1:0]           vld_q, vld_d, smp_q, smp_d;
  logic [DW-1:0]        div_q, div_d;
  logic [SW-1:0]        s_q, s_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d, rx_data_q, rx_data_d;
  logic                 pbad_q, pbad_d, fbad_q, fbad_d, zero_q, zero_d;
  logic                 brk_q, brk_d, brkw_q, brkw_d, done_q, done_d;
  logic                 rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d, overrun_q, overrun_d, break_det_q, break_det_d;
  logic                 tick_s, start_s, dec_s, maj_s, zero_fin_s, xfer_s, load_s;

  // Receive FSM, tick/sample counters and frame capture.
  always_comb begin
    rx_meta_d  = rx;
    rxs_d      = rx_meta_q;
    vld_d      = {vld_q[0], 1'b1};
    // The previous-sample flop stays 0 until the synchroniser holds a genuine line value,
    // so a line held low out of reset never produces a falling edge.
    rxs_prev_d = vld_q[1] ? rxs_q : 1'b0;
    state_d    = state_q;
    s_d        = s_q;
    bit_d      = bit_q;
    smp_d      = smp_q;
    data_d     = data_q;
    pbad_d     = pbad_q;
    fbad_d     = fbad_q;
    zero_d     = zero_q;
    brk_d      = 1'b0;
    brkw_d     = brkw_q;
    done_d     = 1'b0;
    tick_s     = (div_q == DIV_LAST);
    start_s    = (state_q == ST_IDLE) && !brkw_q && rxs_prev_q && !rxs_q;
    dec_s      = tick_s && (state_q != ST_IDLE) && (s_q == S_HI);
    maj_s      = maj3(smp_q[0], smp_q[1], rxs_q);
    zero_fin_s = zero_q & ~maj_s;

    if (start_s || tick_s) begin
      div_d = {DW{1'b0}};
    end else begin
      div_d = div_q + DW'(1);
    end

    if ((state_q != ST_IDLE) && tick_s) begin
      s_d = (s_q == S_LAST) ? {SW{1'b0}} : s_q + SW'(1);
      if (s_q == S_LO) begin
        smp_d[0] = rxs_q;
      end else if (s_q == S_MID) begin
        smp_d[1] = rxs_q;
      end else begin
        smp_d = smp_q;
      end
    end else begin
      smp_d = smp_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (brkw_q) begin
          // After a break, re-arm only once the line has been high for a whole bit time.
          if (!rxs_q) begin
            s_d = {SW{1'b0}};
          end else if (tick_s) begin
            s_d    = (s_q == S_LAST) ? {SW{1'b0}} : s_q + SW'(1);
            brkw_d = (s_q != S_LAST);
          end else begin
            s_d = s_q;
          end
        end else if (start_s) begin
          state_d = ST_START;
          s_d     = {SW{1'b0}};
          pbad_d  = 1'b0;
          fbad_d  = 1'b0;
          zero_d  = 1'b1;
        end else begin
          s_d = {SW{1'b0}};
        end
      end
      ST_START: begin
        if (dec_s) begin
          if (maj_s) begin
            state_d = ST_IDLE;
            s_d     = {SW{1'b0}};
          end else begin
            state_d = ST_DATA;
            bit_d   = 4'd0;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (dec_s) begin
          data_d = {maj_s, data_q[DATA_BITS-1:1]};
          zero_d = zero_fin_s;
          if (bit_q == LAST_DATA) begin
            bit_d   = 4'd0;
            state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAR: begin
        if (dec_s) begin
          pbad_d  = (maj_s != par_exp(data_q));
          zero_d  = zero_fin_s;
          bit_d   = 4'd0;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PAR;
        end
      end
      ST_STOP: begin
        if (dec_s) begin
          fbad_d = fbad_q | ~maj_s;
          zero_d = zero_fin_s;
          if (bit_q == LAST_STOP) begin
            state_d = ST_IDLE;
            s_d     = {SW{1'b0}};
            bit_d   = 4'd0;
            done_d  = 1'b1;
            brk_d   = BRK_EN & zero_fin_s;
            brkw_d  = BRK_EN & zero_fin_s;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = {SW{1'b0}};
      end
    endcase
  end

  // Output register: load one clock after the frame completes, otherwise drain on handshake.
  always_comb begin
    xfer_s       = rx_valid_q & rx_ready;
    load_s       = done_q & ~(BRK_EN & brk_q);
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = rx_valid_q & ~xfer_s;
    overrun_d    = overrun_q & ~xfer_s;
    break_det_d  = BRK_EN & done_q & brk_q;
    if (load_s) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = data_q;
        parity_err_d = pbad_q;
        frame_err_d  = fbad_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b0;
      vld_q        <= 2'b00;
      state_q      <= ST_IDLE;
      div_q        <= {DW{1'b0}};
      s_q          <= {SW{1'b0}};
      bit_q        <= 4'd0;
      smp_q        <= 2'b00;
      data_q       <= {DATA_BITS{1'b0}};
      pbad_q       <= 1'b0;
      fbad_q       <= 1'b0;
      zero_q       <= 1'b0;
      brk_q        <= 1'b0;
      brkw_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_data_q    <= {DATA_BITS{1'b0}};
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rxs_q        <= rxs_d;
      rxs_prev_q   <= rxs_prev_d;
      vld_q        <= vld_d;
      state_q      <= state_d;
      div_q        <= div_d;
      s_q          <= s_d;
      bit_q        <= bit_d;
      smp_q        <= smp_d;
      data_q       <= data_d;
      pbad_q       <= pbad_d;
      fbad_q       <= fbad_d;
      zero_q       <= zero_d;
      brk_q        <= brk_d;
      brkw_q       <= brkw_d;
      done_q       <= done_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
